// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic inter-stage pipeline register with valid/ready
// handshake, a 2-entry skid buffer (main + skid) and synchronous flush.
// Control fields read as zero whenever the stage holds a bubble.
// Optional statistics counters are built when PIPE_STATS_EN is defined;
// otherwise stall_cnt and flush_cnt are tied to zero.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              r_in_ready;
  logic              r_out_valid;

  logic [DATA_W-1:0] w_main_data_nxt;
  logic [CTRL_W-1:0] w_main_ctrl_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;

  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next contents of main/skid; flush wins over everything
  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;

    if (flush) begin
      w_state_nxt     = ST_EMPTY;
      w_main_ctrl_nxt = '0;
      w_skid_ctrl_nxt = '0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = in_data;
            w_main_ctrl_nxt = in_ctrl;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_data_nxt = in_data;
            w_main_ctrl_nxt = in_ctrl;
          end else if (w_in_fire) begin
            w_state_nxt     = ST_FULL;
            w_skid_data_nxt = in_data;
            w_skid_ctrl_nxt = in_ctrl;
          end else if (w_out_fire) begin
            // Draining to a bubble: zero control so the bubble is inert
            w_state_nxt     = ST_EMPTY;
            w_main_ctrl_nxt = '0;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = r_skid_data;
            w_main_ctrl_nxt = r_skid_ctrl;
          end
        end
        default: begin
          w_state_nxt     = ST_EMPTY;
          w_main_ctrl_nxt = '0;
          w_skid_ctrl_nxt = '0;
        end
      endcase
    end
  end

  // Main/skid payload registers and registered handshake flags
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_main_data <= w_main_data_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Saturating counters: downstream back-pressure cycles and effective flushes
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush && (r_state != ST_EMPTY) && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a 2-deep FIFO reference model
// (queue of expected bundles) predicts in_ready/out_valid/out_data/out_ctrl
// and the saturating statistics counters every cycle.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;
  localparam int unsigned NW = 4;
`ifdef PIPE_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          CLK;
  logic          nRST;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          flush;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] flush_cnt;

  ent_t exp_q[$];
  int   m_stall;
  int   m_flush;
  int   nvec;
  int   nerr;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush     (flush),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the reference model
  task automatic check_outputs(input string tag);
    chk({tag, ":in_ready"},  64'(in_ready),  64'(exp_q.size() < 2));
    chk({tag, ":out_valid"}, 64'(out_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk({tag, ":out_data"}, 64'(out_data), 64'(exp_q[0].d));
      chk({tag, ":out_ctrl"}, 64'(out_ctrl), 64'(exp_q[0].c));
    end else begin
      chk({tag, ":out_ctrl"}, 64'(out_ctrl), 64'd0);
    end
    chk({tag, ":stall_cnt"}, 64'(stall_cnt), STATS_EN ? 64'(m_stall) : 64'd0);
    chk({tag, ":flush_cnt"}, 64'(flush_cnt), STATS_EN ? 64'(m_flush) : 64'd0);
  endtask

  // One clock: check, drive inputs, advance model, cross the edge
  task automatic tick(input string tag, input logic iv, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input logic ordy, input logic fl,
                      output logic acc);
    logic fire_in;
    logic fire_out;
    ent_t e;
    check_outputs(tag);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    fire_in  = iv && (exp_q.size() < 2);
    fire_out = (exp_q.size() > 0) && ordy;
    acc      = fire_in && !fl;
    if ((exp_q.size() > 0) && !ordy && (m_stall != 15)) m_stall++;
    if (fl) begin
      if ((exp_q.size() > 0) && (m_flush != 15)) m_flush++;
      exp_q.delete();
    end else begin
      if (fire_out) e = exp_q.pop_front();
      if (fire_in) begin
        e.d = d;
        e.c = c;
        exp_q.push_back(e);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    logic acc;
    int   idx;
    int   n;
    nvec = 0;
    nerr = 0;
    m_stall = 0;
    m_flush = 0;
    nRST      = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA5;
    in_ctrl   = 16'h00C3;
    out_ready = 1'b1;
    flush     = 1'b0;

    // Reset with upstream presenting 0xA5
    repeat (2) begin
      @(negedge CLK);
      check_outputs("reset");
    end
    nRST = 1'b1;
    tick("rst_rel", 1'b1, 64'hA5, 16'h00C3, 1'b1, 1'b0, acc);
    chk("rst_acc", 64'(acc), 64'd1);
    tick("rst_out", 1'b0, 64'h0, 16'h0, 1'b1, 1'b0, acc);

    // Streaming 1..4 at full throughput
    for (int i = 1; i <= 4; i++) begin
      tick("stream", 1'b1, 64'(i), 16'(16'h0100 + i), 1'b1, 1'b0, acc);
      chk("stream_acc", 64'(acc), 64'd1);
    end
    repeat (2) tick("stream_drain", 1'b0, 64'h0, 16'h0, 1'b1, 1'b0, acc);

    // Back-pressure: 1,2 fill main/skid, 3 held upstream
    tick("bp1", 1'b1, 64'd1, 16'h0201, 1'b0, 1'b0, acc);
    tick("bp2", 1'b1, 64'd2, 16'h0202, 1'b0, 1'b0, acc);
    tick("bp3", 1'b1, 64'd3, 16'h0203, 1'b0, 1'b0, acc);
    chk("bp3_blocked", 64'(acc), 64'd0);
    tick("bp3b", 1'b1, 64'd3, 16'h0203, 1'b0, 1'b0, acc);
    n = 0;
    acc = 1'b0;
    while (!acc && n < 10) begin
      tick("bp_rel", 1'b1, 64'd3, 16'h0203, 1'b1, 1'b0, acc);
      n++;
    end
    chk("bp3_accepted", 64'(acc), 64'd1);
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      tick("bp_drain", 1'b0, 64'h0, 16'h0, 1'b1, 1'b0, acc);
      n++;
    end
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Flush in FULL with in_valid high, then flush in ONE discarding in_fire
    tick("fl_a", 1'b1, 64'hAA, 16'hFFFF, 1'b0, 1'b0, acc);
    tick("fl_b", 1'b1, 64'hBB, 16'hFFFF, 1'b0, 1'b0, acc);
    tick("fl_full", 1'b1, 64'hCC, 16'hFFFF, 1'b0, 1'b1, acc);
    tick("fl_after", 1'b0, 64'h0, 16'h0, 1'b1, 1'b0, acc);
    tick("fl_one", 1'b1, 64'h11, 16'hFFFF, 1'b0, 1'b0, acc);
    tick("fl_disc", 1'b1, 64'h22, 16'hFFFF, 1'b1, 1'b1, acc);
    chk("fl_disc_acc", 64'(acc), 64'd0);
    repeat (2) tick("fl_idle", 1'b0, 64'h0, 16'h0, 1'b1, 1'b0, acc);
    // Flush while empty: nothing held, no flush count
    tick("fl_empty", 1'b1, 64'h33, 16'hFFFF, 1'b1, 1'b1, acc);
    tick("fl_empty2", 1'b0, 64'h0, 16'h0, 1'b1, 1'b0, acc);

    // Long stall: stall counter saturates at 15
    tick("st_load", 1'b1, 64'h77, 16'h0777, 1'b0, 1'b0, acc);
    repeat (20) tick("stall", 1'b0, 64'h0, 16'h0, 1'b0, 1'b0, acc);
    chk("stall_sat", 64'(stall_cnt), STATS_EN ? 64'd15 : 64'd0);
    tick("st_drain", 1'b0, 64'h0, 16'h0, 1'b1, 1'b0, acc);

    // Alternating out_ready with data 10..19
    idx = 10;
    n = 0;
    while (idx < 20 && n < 100) begin
      tick("alt", 1'b1, 64'(idx), 16'(16'h5A00 ^ (idx * 3)), n[0], 1'b0, acc);
      if (acc) idx++;
      n++;
    end
    chk("alt_done", 64'(idx), 64'd20);
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      tick("alt_drain", 1'b0, 64'h0, 16'h0, 1'b1, 1'b0, acc);
      n++;
    end
    tick("alt_idle", 1'b0, 64'h0, 16'h0, 1'b1, 1'b0, acc);

    // Asynchronous reset mid-operation drops entries immediately
    tick("mr_a", 1'b1, 64'hE1, 16'h0E01, 1'b0, 1'b0, acc);
    tick("mr_b", 1'b1, 64'hE2, 16'h0E02, 1'b0, 1'b0, acc);
    #2;
    nRST = 1'b0;
    #1;
    exp_q.delete();
    m_stall = 0;
    m_flush = 0;
    check_outputs("mid_rst");
    @(negedge CLK);
    nRST = 1'b1;
    tick("mr_idle", 1'b0, 64'h0, 16'h0, 1'b1, 1'b0, acc);
    tick("mr_after", 1'b0, 64'h0, 16'h0, 1'b1, 1'b0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
